nonce_result_scanner: RTL and testbench

//  Downstream consumer of the SHA-256 nonce hasher. After the hasher asserts done, scans the
//  NUM_NONCES result words it wrote to shared memory (word i = H0 of the hash for nonce i).

---
 rtl/nonce_result_scanner_if.sv | 22 ++
 rtl/nonce_result_scanner.sv | 140 ++++++++++++++
 tb/tb_nonce_result_scanner.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/nonce_result_scanner_if.sv
// Memory bus between the nonce result scanner (master) and the shared
// single-port result memory (slave).
interface nonce_result_scanner_if;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_read_data;

    modport master (
        output mem_clk,
        output mem_we,
        output mem_addr,
        input  mem_read_data
    );

    modport slave (
        input  mem_clk,
        input  mem_we,
        input  mem_addr,
        output mem_read_data
    );
endinterface

// File: rtl/nonce_result_scanner.sv
// Nonce result scanner: after the hasher finishes, reads NUM_NONCES result
// words from shared memory and reports hit count, first hit and minimum hash.
// Reads are pipelined: address issued at edge E, data captured at edge E+2.
module nonce_result_scanner #(
    parameter int NUM_NONCES = 16,
    parameter int NONCE_W    = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [15:0]        result_addr,
    input  logic [31:0]        target,
    output logic               done,
    output logic               found,
    output logic [NONCE_W:0]   hit_count,
    output logic [NONCE_W-1:0] first_hit_nonce,
    output logic [NONCE_W-1:0] best_nonce,
    output logic [31:0]        best_hash,
    nonce_result_scanner_if.master mem
);

    localparam logic [NONCE_W:0]   NUM_L  = (NONCE_W+1)'(NUM_NONCES);
    localparam logic [NONCE_W-1:0] LAST_L = NONCE_W'(NUM_NONCES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [NONCE_W:0]   issue_idx;
    logic [NONCE_W-1:0] cap_idx;
    logic [15:0]        base_q;
    logic [31:0]        target_q;
    logic [15:0]        mem_addr_q;
    logic               issued_q;    // an address was registered at the last edge
    logic               inflight_q;  // memory sampled that address; data valid now
    logic               cap_fire;
    logic               last_cap;
    logic               hit;

    assign mem.mem_clk  = clk;
    assign mem.mem_we   = 1'b0;
    assign mem.mem_addr = mem_addr_q;

    assign cap_fire = inflight_q && (state_q == SCAN || state_q == DRAIN);
    assign last_cap = cap_fire && (cap_idx == LAST_L);
    assign hit      = mem.mem_read_data < target_q;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first, so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:   if (start) state_d = SCAN;
            SCAN:   if (issue_idx >= NUM_L - 1'b1) state_d = DRAIN;
            DRAIN:  if (last_cap) state_d = FINISH;
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address issue, read pipeline tracking and result statistics.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_idx       <= '0;
            cap_idx         <= '0;
            base_q          <= '0;
            target_q        <= '0;
            mem_addr_q      <= '0;
            issued_q        <= 1'b0;
            inflight_q      <= 1'b0;
            done            <= 1'b0;
            found           <= 1'b0;
            hit_count       <= '0;
            first_hit_nonce <= '0;
            best_nonce      <= '0;
            best_hash       <= 32'hFFFF_FFFF;
        end else begin
            inflight_q <= issued_q;
            issued_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q          <= result_addr;
                        target_q        <= target;
                        mem_addr_q      <= result_addr;
                        issued_q        <= 1'b1;
                        issue_idx       <= (NONCE_W+1)'(1);
                        cap_idx         <= '0;
                        done            <= 1'b0;
                        found           <= 1'b0;
                        hit_count       <= '0;
                        first_hit_nonce <= '0;
                        best_nonce      <= '0;
                        best_hash       <= 32'hFFFF_FFFF;
                    end
                end
                SCAN: begin
                    if (issue_idx < NUM_L) begin
                        mem_addr_q <= base_q + 16'(issue_idx);
                        issued_q   <= 1'b1;
                        issue_idx  <= issue_idx + 1'b1;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    found <= (hit_count != '0);
                end
                default: ;
            endcase

            if (cap_fire) begin
                cap_idx <= cap_idx + 1'b1;
                if (hit) begin
                    hit_count <= hit_count + 1'b1;
                    if (hit_count == '0) first_hit_nonce <= cap_idx;
                end
                if (mem.mem_read_data < best_hash) begin
                    best_hash  <= mem.mem_read_data;
                    best_nonce <= cap_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Directed bench for nonce_result_scanner with a one-cycle-latency memory model.
module tb_nonce_result_scanner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] result_addr;
    logic [31:0] target;
    logic        done;
    logic        found;
    logic [6:0]  hit_count;
    logic [5:0]  first_hit_nonce;
    logic [5:0]  best_nonce;
    logic [31:0] best_hash;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    logic [31:0] mem_arr [0:65535];

    nonce_result_scanner_if mif ();

    nonce_result_scanner #(.NUM_NONCES(16), .NONCE_W(6)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .result_addr     (result_addr),
        .target          (target),
        .done            (done),
        .found           (found),
        .hit_count       (hit_count),
        .first_hit_nonce (first_hit_nonce),
        .best_nonce      (best_nonce),
        .best_hash       (best_hash),
        .mem             (mif.master)
    );

    always #5 clk = ~clk;

    // Memory samples the address at the edge after it was registered.
    always @(posedge mif.mem_clk) mif.mem_read_data <= mem_arr[mif.mem_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string pre);
        check({pre, "_done"},     64'(done), 64'd0);
        check({pre, "_found"},    64'(found), 64'd0);
        check({pre, "_hits"},     64'(hit_count), 64'd0);
        check({pre, "_first"},    64'(first_hit_nonce), 64'd0);
        check({pre, "_bnonce"},   64'(best_nonce), 64'd0);
        check({pre, "_bhash"},    64'(best_hash), 64'hFFFF_FFFF);
        check({pre, "_mem_addr"}, 64'(mif.mem_addr), 64'd0);
        check({pre, "_mem_we"},   64'(mif.mem_we), 64'd0);
    endtask

    task automatic check_results(input string pre, input int l, input logic f,
                                 input int hc, input int fh, input int bn, input logic [31:0] bh);
        check({pre, "_latency"}, 64'(l), 64'd18);
        check({pre, "_found"},   64'(found), 64'(f));
        check({pre, "_hits"},    64'(hit_count), 64'(hc));
        check({pre, "_first"},   64'(first_hit_nonce), 64'(fh));
        check({pre, "_bnonce"},  64'(best_nonce), 64'(bn));
        check({pre, "_bhash"},   64'(best_hash), 64'(bh));
    endtask

    // Start a scan and wait for done. Optional mid-scan start pulses (with
    // perturbed target/address), reset at a given cycle, and address tracing.
    task automatic run_scan(input logic [15:0] addr, input logic [31:0] tgt,
                            input int p1, input int p2, input int rst_at,
                            input bit trace, output int l);
        l = 0;
        @(negedge clk);
        result_addr = addr;
        target      = tgt;
        start       = 1'b1;
        @(posedge clk);
        #1;
        if (trace) check("t4_addr_c0", 64'(mif.mem_addr), 64'(addr));
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start = (cyc == p1 || cyc == p2);
            if (start) begin
                target      = 32'h0;
                result_addr = 16'd400;
            end
            @(posedge clk);
            #1;
            if (trace && cyc <= 16) begin
                check($sformatf("t4_addr_c%0d", cyc), 64'(mif.mem_addr),
                      64'(16'(addr + 16'(cyc < 16 ? cyc : 15))));
                check($sformatf("t4_we_c%0d", cyc), 64'(mif.mem_we), 64'd0);
            end
            if (cyc == rst_at) begin
                reset_n = 1'b0;
                #1;
                start = 1'b0;
                return;
            end
            if (done) begin
                l = cyc;
                break;
            end
        end
        @(negedge clk);
        start = 1'b0;
        if (l == 0 && rst_at < 0) check("scan_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        result_addr = '0;
        target      = '0;
        for (int a = 0; a < 65536; a++) mem_arr[a] = 32'h5000_0000;
        for (int i = 0; i < 16; i++) mem_arr[200 + i] = i * 32'h1000_0000 + 32'd1;
        for (int i = 0; i < 16; i++) mem_arr[300 + i] = 32'hFFFF_FFFF;
        for (int i = 0; i < 16; i++) mem_arr[400 + i] = 32'h8000_0000;
        mem_arr[405] = 32'h0000_00AA;
        mem_arr[409] = 32'h0000_00AA;
        mem_arr[16'h0003] = 32'h0000_0010;  // nonce 5 when based at FFFE

        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // T1: three hits at nonces 0..2, minimum at nonce 0.
        run_scan(16'd200, 32'h3000_0000, -1, -1, -1, 1'b0, lat);
        check_results("t1", lat, 1'b1, 3, 0, 0, 32'h0000_0001);

        // T2: all-ones data and target: nothing strictly below, ties keep nonce 0.
        run_scan(16'd300, 32'hFFFF_FFFF, -1, -1, -1, 1'b0, lat);
        check_results("t2", lat, 1'b0, 0, 0, 0, 32'hFFFF_FFFF);

        // T3: duplicate minimum at 5 and 9; lower index wins.
        run_scan(16'd400, 32'h0000_0100, -1, -1, -1, 1'b0, lat);
        check_results("t3", lat, 1'b1, 2, 5, 5, 32'h0000_00AA);

        // T4: address wrap from FFFE; target 0 allows no hits.
        run_scan(16'hFFFE, 32'h0, -1, -1, -1, 1'b1, lat);
        check_results("t4", lat, 1'b0, 0, 0, 5, 32'h0000_0010);

        // T5: reset at cycle 8 aborts, then a clean scan completes.
        run_scan(16'd200, 32'h3000_0000, -1, -1, 8, 1'b0, lat);
        check_reset("t5_abort");
        @(negedge clk);
        reset_n = 1'b1;
        run_scan(16'd400, 32'h0000_0100, -1, -1, -1, 1'b0, lat);
        check_results("t5", lat, 1'b1, 2, 5, 5, 32'h0000_00AA);

        // T6: start pulses mid-scan with altered inputs are ignored.
        run_scan(16'd200, 32'h3000_0000, 3, 10, -1, 1'b0, lat);
        check_results("t6a", lat, 1'b1, 3, 0, 0, 32'h0000_0001);
        run_scan(16'd200, 32'h1000_0002, -1, -1, -1, 1'b0, lat);
        check_results("t6b", lat, 1'b1, 2, 0, 0, 32'h0000_0001);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
